// File: rtl/des_key_schedule.sv
// Iterative DES / 3-key TDES round-key generator streaming one 48-bit subkey per handshake.
// Optional key-byte odd-parity screening is enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_key_schedule #(
  parameter int NUM_KEYS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [64*NUM_KEYS-1:0]  key_in,
  input  logic                    decrypt,
  input  logic                    key_valid,
  output logic                    key_ready,
  output logic [47:0]             subkey,
  output logic                    subkey_valid,
  input  logic                    subkey_ready,
  output logic [3:0]              round_idx,
  output logic [1:0]              stage_idx,
  output logic                    last
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic                    parity_err
`endif
);

  generate
    if ((NUM_KEYS != 1) && (NUM_KEYS != 3)) begin : g_bad_num_keys
      $error("des_key_schedule: NUM_KEYS must be 1 or 3");
    end
  endgenerate

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] LAST_STAGE = 2'(NUM_KEYS - 1);

  // Source bit numbers (DES numbering, bit 1 = MSB), first entry is output bit 1.
  localparam logic [56*7-1:0] PC1_TAB = {
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  localparam logic [48*7-1:0] PC2_TAB = {
    7'd14, 7'd17, 7'd11, 7'd24, 7'd1,  7'd5,
    7'd3,  7'd28, 7'd15, 7'd6,  7'd21, 7'd10,
    7'd23, 7'd19, 7'd12, 7'd4,  7'd26, 7'd8,
    7'd16, 7'd7,  7'd27, 7'd20, 7'd13, 7'd2,
    7'd41, 7'd52, 7'd31, 7'd37, 7'd47, 7'd55,
    7'd30, 7'd40, 7'd51, 7'd45, 7'd33, 7'd48,
    7'd44, 7'd49, 7'd39, 7'd56, 7'd34, 7'd53,
    7'd46, 7'd42, 7'd50, 7'd36, 7'd29, 7'd32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [56*7-1:0] tab;
    logic [6:0]      src;
    logic [5:0]      idx;
    pc1 = 56'd0;
    tab = PC1_TAB;
    for (int j = 0; j < 32'sd56; j++) begin
      src = tab[56*7-1 -: 7];
      idx = 6'(7'd64 - src);
      pc1 = {pc1[54:0], k[idx]};
      tab = tab << 7'd7;
    end
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [48*7-1:0] tab;
    logic [6:0]      src;
    logic [5:0]      idx;
    pc2 = 48'd0;
    tab = PC2_TAB;
    for (int j = 0; j < 32'sd48; j++) begin
      src = tab[48*7-1 -: 7];
      idx = 6'(7'd56 - src);
      pc2 = {pc2[46:0], cd[idx]};
      tab = tab << 7'd7;
    end
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] h, input logic left, input logic two);
    case ({left, two})
      2'b10:   rot28 = {h[26:0], h[27]};
      2'b11:   rot28 = {h[25:0], h[27:26]};
      2'b00:   rot28 = {h[0], h[27:1]};
      2'b01:   rot28 = {h[1:0], h[27:2]};
      default: rot28 = h;
    endcase
  endfunction

  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic left, input logic two);
    rot_cd = {rot28(cd[55:28], left, two), rot28(cd[27:0], left, two)};
  endfunction

  // Shift schedule S[n], n = 1..16: single shift only at 1, 2, 9 and 16.
  function automatic logic shift_two(input logic [4:0] n);
    case (n)
      5'd1, 5'd2, 5'd9, 5'd16: shift_two = 1'b0;
      default:                 shift_two = 1'b1;
    endcase
  endfunction

  function automatic logic [63:0] key_of(input logic [64*NUM_KEYS-1:0] keys, input logic [1:0] k);
    key_of = 64'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (k == 2'(i + 32'sd1)) key_of = keys[64*(NUM_KEYS-1-i) +: 64];
    end
  endfunction

  // Decrypt jobs walk the keys from the last one down; the middle TDES stage flips direction.
  function automatic logic [55:0] load_cd(input logic [64*NUM_KEYS-1:0] keys,
                                          input logic job_dec, input logic [1:0] stage);
    logic [1:0]  kidx;
    logic        sdec;
    logic [55:0] base_cd;
    kidx    = job_dec ? (2'(NUM_KEYS) - stage) : (stage + 2'd1);
    sdec    = job_dec ^ (stage == 2'd1);
    base_cd = pc1(key_of(keys, kidx));
    load_cd = sdec ? base_cd : rot_cd(base_cd, 1'b1, 1'b0);
  endfunction

`ifdef DES_KEY_PARITY_CHECK_EN
  function automatic logic keys_parity_ok(input logic [64*NUM_KEYS-1:0] keys);
    keys_parity_ok = 1'b1;
    for (int b = 0; b < 8*NUM_KEYS; b++) begin
      keys_parity_ok = keys_parity_ok & (^keys[8*b +: 8]);
    end
  endfunction
`endif

  state_t                  state_r, state_s;
  logic [55:0]             cd_r, cd_s;
  logic [64*NUM_KEYS-1:0]  key_r, key_s;
  logic                    dec_r, dec_s;
  logic [3:0]              round_r, round_s;
  logic [1:0]              stage_r, stage_s;
  logic                    valid_r, valid_s;
  logic [47:0]             subkey_r, subkey_s;
  logic                    last_r, last_s;
  logic                    stage_dec_s;
  logic [4:0]              shift_n_s;
  logic                    key_ok_s;

`ifdef DES_KEY_PARITY_CHECK_EN
  assign key_ok_s = keys_parity_ok(key_in);
`else
  assign key_ok_s = 1'b1;
`endif

  // Next-state, round-key schedule and output computation.
  always_comb begin
    state_s     = state_r;
    cd_s        = cd_r;
    key_s       = key_r;
    dec_s       = dec_r;
    round_s     = round_r;
    stage_s     = stage_r;
    valid_s     = valid_r;
    stage_dec_s = dec_r ^ (stage_r == 2'd1);
    shift_n_s   = stage_dec_s ? (5'd16 - {1'b0, round_r}) : ({1'b0, round_r} + 5'd2);
    case (state_r)
      IDLE: begin
        valid_s = 1'b0;
        if (key_valid && key_ok_s) begin
          state_s = RUN;
          key_s   = key_in;
          dec_s   = decrypt;
          cd_s    = load_cd(key_in, decrypt, 2'd0);
          round_s = 4'd0;
          stage_s = 2'd0;
          valid_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (round_r != 4'd15) begin
            round_s = round_r + 4'd1;
            cd_s    = rot_cd(cd_r, !stage_dec_s, shift_two(shift_n_s));
          end else if (stage_r != LAST_STAGE) begin
            round_s = 4'd0;
            stage_s = stage_r + 2'd1;
            cd_s    = load_cd(key_r, dec_r, stage_r + 2'd1);
          end else begin
            state_s = IDLE;
            valid_s = 1'b0;
            round_s = 4'd0;
            stage_s = 2'd0;
          end
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase
    subkey_s = valid_s ? pc2(cd_s) : 48'd0;
    last_s   = valid_s && (round_s == 4'd15) && (stage_s == LAST_STAGE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cd_r     <= 56'd0;
      key_r    <= '0;
      dec_r    <= 1'b0;
      round_r  <= 4'd0;
      stage_r  <= 2'd0;
      valid_r  <= 1'b0;
      subkey_r <= 48'd0;
      last_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cd_r     <= cd_s;
      key_r    <= key_s;
      dec_r    <= dec_s;
      round_r  <= round_s;
      stage_r  <= stage_s;
      valid_r  <= valid_s;
      subkey_r <= subkey_s;
      last_r   <= last_s;
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic perr_s, perr_r;

  // A rejected key raises the error flag for the cycle after the attempt.
  always_comb begin
    perr_s = (state_r == IDLE) && key_valid && !key_ok_s;
  end

  // Parity error flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_r <= 1'b0;
    end else begin
      perr_r <= perr_s;
    end
  end

  assign parity_err = perr_r;
`endif

  assign key_ready    = (state_r == IDLE) && !rst;
  assign subkey       = subkey_r;
  assign subkey_valid = valid_r;
  assign round_idx    = round_r;
  assign stage_idx    = stage_r;
  assign last         = last_r;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: single DES and 3-key TDES instances, stalls, reset abort,
// and (with DES_KEY_PARITY_CHECK_EN) key parity screening.
module tb_des_key_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [63:0]  key1_in;
  logic         dec1, kv1, kr1, skv1, skr1, last1;
  logic [47:0]  sk1;
  logic [3:0]   ri1;
  logic [1:0]   si1;

  logic [191:0] key3_in;
  logic         dec3, kv3, kr3, skv3, skr3, last3;
  logic [47:0]  sk3;
  logic [3:0]   ri3;
  logic [1:0]   si3;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic perr1, perr3;
`endif

  des_key_schedule #(.NUM_KEYS(1)) u_des1 (
    .clk(clk), .rst(rst), .key_in(key1_in), .decrypt(dec1), .key_valid(kv1), .key_ready(kr1),
    .subkey(sk1), .subkey_valid(skv1), .subkey_ready(skr1), .round_idx(ri1), .stage_idx(si1),
    .last(last1)
`ifdef DES_KEY_PARITY_CHECK_EN
    , .parity_err(perr1)
`endif
  );

  des_key_schedule #(.NUM_KEYS(3)) u_des3 (
    .clk(clk), .rst(rst), .key_in(key3_in), .decrypt(dec3), .key_valid(kv3), .key_ready(kr3),
    .subkey(sk3), .subkey_valid(skv3), .subkey_ready(skr3), .round_idx(ri3), .stage_idx(si3),
    .last(last3)
`ifdef DES_KEY_PARITY_CHECK_EN
    , .parity_err(perr3)
`endif
  );

  localparam logic [63:0] KEY_STD  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD  = 64'h133457799BBCDFF0;
  localparam logic [63:0] KEY_ZERO = 64'h0101010101010101;
  localparam logic [63:0] KEY_ONES = 64'hFEFEFEFEFEFEFEFE;

  // K1..K16 of the classic worked example for KEY_STD.
  localparam logic [47:0] KS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  ri;
    logic [1:0]  si;
    logic        last;
  } beat_t;

  beat_t q1[$];
  beat_t q3[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Record every beat that will be accepted at the coming rising edge.
  always @(negedge clk) begin
    if (skv1 === 1'b1 && skr1 === 1'b1) q1.push_back(beat_t'({sk1, ri1, si1, last1}));
    if (skv3 === 1'b1 && skr3 === 1'b1) q3.push_back(beat_t'({sk3, ri3, si3, last3}));
  end

  logic        hold_en = 1'b0;
  logic        pv, pr;
  logic [47:0] psk;
  logic [3:0]  pri;
  logic [1:0]  psi;

  // While stalled, the single-DES outputs must not move.
  always @(negedge clk) begin
    if (hold_en && pv && !pr) begin
      check_eq("hold_subkey", sk1, psk);
      check_eq("hold_round", ri1, pri);
      check_eq("hold_stage", si1, psi);
    end
    pv  <= skv1;
    pr  <= skr1;
    psk <= sk1;
    pri <= ri1;
    psi <= si1;
  end

  task automatic run1(input string tag, input logic [63:0] key, input logic dec,
                      input logic [63:0] low_mask, input int rst_at, input int exp_cycles);
    int c;
    q1.delete();
    @(posedge clk); #1;
    check_eq({tag, "_ready_idle"}, kr1, 1);
    key1_in = key; dec1 = dec; kv1 = 1'b1; skr1 = 1'b1;
    @(posedge clk); #1;
    kv1 = 1'b0;
    check_eq({tag, "_first_valid"}, skv1, 1);
    check_eq({tag, "_ready_run"}, kr1, 0);
    c = 0;
    while (skv1 === 1'b1 && c < 200) begin
      skr1    = !low_mask[c % 64];
      kv1     = (c == 8);
      key1_in = (c == 8) ? 64'h0 : key;
      if (c == 8) check_eq({tag, "_ready_busy"}, kr1, 0);
      if (c == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      c++;
    end
    kv1 = 1'b0; skr1 = 1'b1; key1_in = key;
    check_eq({tag, "_cycles"}, c, exp_cycles);
  endtask

  task automatic verify1(input string tag, input logic dec, input int n);
    check_eq({tag, "_beats"}, q1.size(), n);
    for (int i = 0; i < n && i < q1.size(); i++) begin
      check_eq({tag, "_subkey"}, q1[i].sk, KS[dec ? 15 - i : i]);
      check_eq({tag, "_round"}, q1[i].ri, i);
      check_eq({tag, "_stage"}, q1[i].si, 0);
      check_eq({tag, "_last"}, q1[i].last, (i == 15));
    end
  endtask

  task automatic run3(input string tag, input logic [191:0] keys, input logic dec);
    int c;
    q3.delete();
    @(posedge clk); #1;
    check_eq({tag, "_ready_idle"}, kr3, 1);
    key3_in = keys; dec3 = dec; kv3 = 1'b1; skr3 = 1'b1;
    @(posedge clk); #1;
    kv3 = 1'b0;
    check_eq({tag, "_first_valid"}, skv3, 1);
    c = 0;
    while (skv3 === 1'b1 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check_eq({tag, "_cycles"}, c, 48);
    check_eq({tag, "_ready_end"}, kr3, 1);
  endtask

  // kind per stage: 0 = KEY_STD forward, 1 = KEY_STD reversed, 2 = all zero, 3 = all one.
  task automatic verify3(input string tag, input int k0, input int k1, input int k2);
    int s, r, kind;
    logic [47:0] exp;
    check_eq({tag, "_beats"}, q3.size(), 48);
    for (int i = 0; i < 48 && i < q3.size(); i++) begin
      s    = i / 16;
      r    = i % 16;
      kind = (s == 0) ? k0 : (s == 1) ? k1 : k2;
      exp  = (kind == 0) ? KS[r] : (kind == 1) ? KS[15 - r] :
             (kind == 2) ? 48'h0 : 48'hFFFFFFFFFFFF;
      check_eq({tag, "_subkey"}, q3[i].sk, exp);
      check_eq({tag, "_round"}, q3[i].ri, r);
      check_eq({tag, "_stage"}, q3[i].si, s);
      check_eq({tag, "_last"}, q3[i].last, (i == 47));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timed out");
  end

  initial begin
    rst = 1'b1;
    kv1 = 1'b0; key1_in = 64'h0; dec1 = 1'b0; skr1 = 1'b1;
    kv3 = 1'b0; key3_in = 192'h0; dec3 = 1'b0; skr3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", skv1, 0);
    check_eq("rst_subkey", sk1, 0);
    check_eq("rst_round", ri1, 0);
    check_eq("rst_stage", si1, 0);
    check_eq("rst_last", last1, 0);
    check_eq("rst_ready", kr1, 0);
    check_eq("rst_valid3", skv3, 0);
    check_eq("rst_ready3", kr3, 0);
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", kr1, 1);
    check_eq("ready_after_rst3", kr3, 1);

    run1("enc", KEY_STD, 1'b0, 64'h0, -1, 16);
    verify1("enc", 1'b0, 16);
    check_eq("enc_idle_valid", skv1, 0);
    check_eq("enc_idle_subkey", sk1, 0);
    check_eq("enc_idle_ready", kr1, 1);

    run1("dec", KEY_STD, 1'b1, 64'h0, -1, 16);
    verify1("dec", 1'b1, 16);

    hold_en = 1'b1;
    run1("stall", KEY_STD, 1'b0, 64'h00000000000210E0, -1, 21);
    hold_en = 1'b0;
    verify1("stall", 1'b0, 16);

    run1("abort", KEY_STD, 1'b0, 64'h0, 7, 8);
    check_eq("abort_valid", skv1, 0);
    check_eq("abort_round", ri1, 0);
    check_eq("abort_ready_in_rst", kr1, 0);
    check_eq("abort_beats", q1.size(), 8);
    @(posedge clk); #1;
    check_eq("abort_still_idle", skv1, 0);
    rst = 1'b0;
    #1;
    check_eq("abort_ready_after", kr1, 1);
    run1("after_abort", KEY_STD, 1'b0, 64'h0, -1, 16);
    verify1("after_abort", 1'b0, 16);

`ifdef DES_KEY_PARITY_CHECK_EN
    @(posedge clk); #1;
    key1_in = KEY_BAD; dec1 = 1'b0; kv1 = 1'b1;
    @(posedge clk); #1;
    kv1 = 1'b0;
    check_eq("perr_pulse", perr1, 1);
    check_eq("perr_no_valid", skv1, 0);
    check_eq("perr_ready", kr1, 1);
    @(posedge clk); #1;
    check_eq("perr_cleared", perr1, 0);
    check_eq("perr_still_idle", skv1, 0);
    run1("parity_ok", KEY_STD, 1'b0, 64'h0, -1, 16);
    check_eq("parity_ok_flag", perr1, 0);
    verify1("parity_ok", 1'b0, 16);
`else
    run1("parity_ignored", KEY_BAD, 1'b0, 64'h0, -1, 16);
    verify1("parity_ignored", 1'b0, 16);
`endif

    run3("tdes_enc_same", {KEY_STD, KEY_STD, KEY_STD}, 1'b0);
    verify3("tdes_enc_same", 0, 1, 0);
    run3("tdes_dec_same", {KEY_STD, KEY_STD, KEY_STD}, 1'b1);
    verify3("tdes_dec_same", 1, 0, 1);
    run3("tdes_enc_mix", {KEY_STD, KEY_ZERO, KEY_ONES}, 1'b0);
    verify3("tdes_enc_mix", 0, 2, 3);
    run3("tdes_dec_mix", {KEY_STD, KEY_ZERO, KEY_ONES}, 1'b1);
    verify3("tdes_dec_mix", 3, 2, 1);
`ifdef DES_KEY_PARITY_CHECK_EN
    check_eq("tdes_parity_flag", perr3, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
